// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, default sizing and the pending-entry record for the
// register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int REG_AW       = 5;
    localparam int DATA_W       = 32;
    localparam int PEND_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    // One buffered multi-cycle-unit result waiting for the write port.
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } pend_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline, md-unit and register-file write-port signals.
// slave = arbiter side, master = the environment driving it.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic              pipe_we;
    logic [REG_AW-1:0] pipe_a;
    logic [DATA_W-1:0] pipe_wd;
    logic              md_valid;
    logic              md_ready;
    logic [REG_AW-1:0] md_a;
    logic [DATA_W-1:0] md_wd;
    logic              stall;
    logic              grf_we;
    logic [REG_AW-1:0] grf_a;
    logic [DATA_W-1:0] grf_wd;
    logic [1:0]        pend_cnt;

    modport slave (
        input  pipe_we, pipe_a, pipe_wd, md_valid, md_a, md_wd,
        output md_ready, stall, grf_we, grf_a, grf_wd, pend_cnt
    );

    modport master (
        output pipe_we, pipe_a, pipe_wd, md_valid, md_a, md_wd,
        input  md_ready, stall, grf_we, grf_a, grf_wd, pend_cnt
    );

endinterface

// File: rtl/wb_pend_fifo.sv
// Small FIFO holding md results until the write port is free.
// Push into a full FIFO or pop from an empty one is ignored.
module wb_pend_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  pend_entry_t       push_data_i,
    input  logic              pop_i,
    output pend_entry_t       head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);

    pend_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage needs no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Pointer and occupancy update; push+pop together keeps the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline
// writeback and buffered md results. The pipeline normally wins; after
// STARVE_LIMIT consecutive wins over a waiting entry the pipeline is
// stalled for one cycle so the head entry drains.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int PEND_DEPTH   = wb_port_arbiter_pkg::PEND_DEPTH,
    parameter int STARVE_LIMIT = wb_port_arbiter_pkg::STARVE_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    wb_port_arbiter_if.slave   bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(PEND_DEPTH + 1);

    pend_entry_t       push_data, head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic              push, pop, pipe_eff, stall_c, md_ready_c;
    logic [SW-1:0]     starve_q, starve_d;
    logic              grf_we_q, grf_we_d;
    logic [REG_AW-1:0] grf_a_q, grf_a_d;
    logic [DATA_W-1:0] grf_wd_q, grf_wd_d;

    assign push_data = '{addr: bus.md_a, data: bus.md_wd};

    wb_pend_fifo #(.DEPTH(PEND_DEPTH)) u_pend (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    // Arbitration: stall depends only on registered state; pipeline wins
    // unless stalled or targeting r0, otherwise a waiting entry pops.
    always_comb begin
        stall_c    = (starve_q == SW'(STARVE_LIMIT)) && !fifo_empty;
        md_ready_c = !fifo_full && !reset;
        push       = bus.md_valid && md_ready_c;
        pipe_eff   = bus.pipe_we && (bus.pipe_a != '0) && !stall_c;
        pop        = !fifo_empty && !pipe_eff;

        grf_we_d = 1'b0;
        grf_a_d  = grf_a_q;
        grf_wd_d = grf_wd_q;
        if (pipe_eff) begin
            grf_we_d = 1'b1;
            grf_a_d  = bus.pipe_a;
            grf_wd_d = bus.pipe_wd;
        end else if (pop && (head.addr != '0)) begin
            grf_we_d = 1'b1;
            grf_a_d  = head.addr;
            grf_wd_d = head.data;
        end

        if (fifo_empty || pop)
            starve_d = '0;
        else if (pipe_eff)
            starve_d = starve_q + 1'b1;
        else
            starve_d = starve_q;
    end

    // Register the winner and the starvation count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grf_we_q <= 1'b0;
            grf_a_q  <= '0;
            grf_wd_q <= '0;
            starve_q <= '0;
        end else begin
            grf_we_q <= grf_we_d;
            grf_a_q  <= grf_a_d;
            grf_wd_q <= grf_wd_d;
            starve_q <= starve_d;
        end
    end

    assign bus.md_ready = md_ready_c;
    assign bus.stall    = stall_c;
    assign bus.grf_we   = grf_we_q;
    assign bus.grf_a    = grf_a_q;
    assign bus.grf_wd   = grf_wd_q;
    assign bus.pend_cnt = 2'(fifo_cnt);

endmodule
